axis_labcontrol_dispatch: RTL and testbench
===========================================

AXIS_LABCONTROL_DISPATCH -- requirements
Module: axis_labcontrol_dispatch

Interface
REQ-001 SHALL have parameter LC_ADDRESS, default 'hFF: LabControl address this block answers to.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: words per channel FIFO, power of 2, range 2..16.
REQ-003 SHALL have parameter TWOS_COMPL, default 1: sign-extend 16-bit LC data to AXIS width when 1, zero-extend when 0.
REQ-004 SHALL have parameter AXIS_DATA_WIDTH, default 16: per-channel output width, at least 16.
REQ-005 SHALL have port m_axis_aclk, input, 1: single clock; one clock, reset synchronous active-high.
REQ-006 SHALL have port m_axis_areset, input, 1: synchronous active-high reset.
REQ-007 SHALL have ports DIOA, DIOB, DIOC, DIOD, input, 8 each: LabControl bus; data = {DIOA,DIOB}, address = DIOC, subbus = DIOD[4:2], direction = DIOD[1], strobe = DIOD[0].
REQ-008 SHALL have port m_axis_tdata, output, 4*AXIS_DATA_WIDTH: channel n occupies bits [n*W +: W].
REQ-009 SHALL have port m_axis_tvalid, output, 4: per-channel valid.
REQ-010 SHALL have port m_axis_tready, input, 4: per-channel ready.
REQ-011 SHALL have port ovf_clear, input, 1: one-cycle pulse clearing the overflow flags.
REQ-012 SHALL have port ovf_flag, output, 4: sticky per-channel overflow.
REQ-013 SHALL have port unmapped_flag, output, 1: sticky, set by an accepted write with subbus 4..7.

Function
REQ-014 SHALL pass strobe through a 2-flop synchroniser plus a rising-edge detector; the pulse is high for exactly one cycle per strobe rising edge.
REQ-015 SHALL accept a write on the pulse cycle only when address == LC_ADDRESS and direction == 0; DIOA..DIOC are sampled in that same cycle.
REQ-016 SHALL route an accepted write with subbus 0..3 to the FIFO of channel = subbus.
REQ-017 SHALL drop an accepted write with subbus 4..7 and set unmapped_flag.
REQ-018 Latency: strobe first sampled high at edge E0 SHALL give FIFO write at E2; m_axis_tvalid[n] SHALL be high after E2 if the FIFO was empty.
REQ-019 Each FIFO SHALL be first-word-fall-through: tdata is valid whenever tvalid is high and SHALL be held stable until tvalid & tready.
REQ-020 A transfer on channel n SHALL occur on an edge with tvalid[n] & tready[n]; order per channel SHALL be preserved.
REQ-021 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL range 0..FIFO_DEPTH.
REQ-022 A write to a full FIFO with a simultaneous pop SHALL be accepted, leaving occupancy unchanged.
REQ-023 A write to a full FIFO without a pop SHALL be dropped and SHALL set ovf_flag[n]; existing contents SHALL be unchanged.
REQ-024 Channels SHALL be independent; a stalled channel SHALL NOT block the others.
REQ-025 Width: if TWOS_COMPL=1, bit 15 SHALL be replicated into bits [W-1:16]; otherwise those bits SHALL be 0.
REQ-026 If ovf_clear and a new overflow occur in the same cycle, the flag SHALL end up set; the same rule SHALL apply to unmapped_flag.

Reset
REQ-027 While m_axis_areset is high at an edge, all FIFOs SHALL empty, pointers SHALL go to 0 and m_axis_tvalid SHALL go to 0.
REQ-028 Reset SHALL clear ovf_flag, unmapped_flag and the synchroniser/edge flops.
REQ-029 m_axis_tdata SHALL read as 0 after reset.
REQ-030 A strobe high during reset SHALL NOT produce a write after reset release; only a later rising edge SHALL.
REQ-031 Reset mid-transfer SHALL discard all buffered words with no partial outputs.

Configuration
REQ-032 With macro LC_DISPATCH_DROPCNT_EN defined, the block SHALL add output drop_count, 8 bits.
REQ-033 drop_count SHALL count overflow and unmapped drops, saturate at 255 and clear on reset or ovf_clear.
REQ-034 Without LC_DISPATCH_DROPCNT_EN the port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-035 Write addr FF, subbus 1, data 0x1234, tready=0 -> tvalid=4'b0010 three edges after strobe; tdata ch1 = 0x1234.
REQ-036 Write addr FE, and separately addr FF with direction=1 -> no tvalid; all flags stay 0.
REQ-037 Ch0 tready=0, five writes 0x0001..0x0005 with FIFO_DEPTH=4 -> ovf_flag[0]=1; draining yields 1,2,3,4; drop_count=1 when enabled.
REQ-038 Ch2 full, fifth write on the same edge as a pop -> no overflow; drain order preserved.
REQ-039 W=24, data 0x8001: TWOS_COMPL=1 -> 0xFF8001; TWOS_COMPL=0 -> 0x008001.
REQ-040 Subbus 5 write -> unmapped_flag=1; then strobe held high through a reset pulse -> no write after release.

Source files
------------

// File: rtl/axis_labcontrol_dispatch.sv
// ---------------------------------------------------------------------------
// axis_labcontrol_dispatch
//
// Receives LabControl bus writes and delivers them into four independent
// AXI-Stream channels. Each channel has its own first-word-fall-through FIFO.
//
// Ports
//   m_axis_aclk, m_axis_areset  : clock and synchronous active-high reset
//   DIOA, DIOB, DIOC, DIOD      : LabControl bus. data = {DIOA,DIOB},
//                                 address = DIOC, subbus = DIOD[4:2],
//                                 direction = DIOD[1], strobe = DIOD[0]
//   m_axis_tdata/tvalid/tready  : four channels. Channel n data is at
//                                 [n*W +: W]
//   ovf_clear                   : one-cycle pulse that clears the sticky flags
//   ovf_flag                    : sticky per-channel overflow
//   unmapped_flag               : sticky, set by an accepted write to subbus 4..7
//   drop_count                  : present only with LC_DISPATCH_DROPCNT_EN.
//                                 Saturating count of dropped writes.
//
// Optional feature macro: LC_DISPATCH_DROPCNT_EN
//
// Handshake: a word moves on channel n at a rising edge where both
// m_axis_tvalid[n] and m_axis_tready[n] are high. While tvalid[n] is high,
// tdata for channel n does not change until that transfer takes place.
// ---------------------------------------------------------------------------
module axis_labcontrol_dispatch #(
  parameter logic [7:0] LC_ADDRESS      = 8'hFF,
  parameter int         FIFO_DEPTH      = 4,
  parameter int         TWOS_COMPL      = 1,
  parameter int         AXIS_DATA_WIDTH = 16
) (
  input  logic                         m_axis_aclk,
  input  logic                         m_axis_areset,
  input  logic [7:0]                   DIOA,
  input  logic [7:0]                   DIOB,
  input  logic [7:0]                   DIOC,
  input  logic [7:0]                   DIOD,
  output logic [4*AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [3:0]                   m_axis_tvalid,
  input  logic [3:0]                   m_axis_tready,
  input  logic                         ovf_clear,
  output logic [3:0]                   ovf_flag,
  output logic                         unmapped_flag
`ifdef LC_DISPATCH_DROPCNT_EN
  ,
  output logic [7:0]                   drop_count
`endif
);

  localparam int W     = AXIS_DATA_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  // Strobe synchroniser and edge detector
  logic       strb_s1_q, strb_s2_q, strb_s3_q;
  // fill_q[1] means strb_s2_q holds a real post-reset sample. armed_q is set
  // only after a low strobe has been seen. Because of this, a strobe that was
  // already high during reset cannot look like a fresh rising edge.
  logic [1:0] fill_q;
  logic       armed_q;
  logic       strobe_pulse;
  logic       accept;
  logic [2:0] subbus;
  logic [15:0] lc_data;
  logic [W-1:0] wr_data;
  logic       unused_diod;

  // Channel FIFO state
  logic [W-1:0]     mem_q   [4][FIFO_DEPTH];
  logic [AW-1:0]    wptr_q  [4];
  logic [AW-1:0]    rptr_q  [4];
  logic [CNT_W-1:0] count_q [4];
  logic [CNT_W-1:0] count_d [4];
  logic [3:0]       full, pop, push_req, push, ovf_new;
  logic             unm_new;

  logic [3:0] ovf_flag_q;
  logic       unmapped_q;

  assign strobe_pulse = strb_s2_q & ~strb_s3_q & armed_q;
  assign subbus       = DIOD[4:2];
  assign lc_data      = {DIOA, DIOB};
  assign accept       = strobe_pulse & (DIOC == LC_ADDRESS) & ~DIOD[1];
  assign unm_new      = accept & subbus[2];
  assign unused_diod  = ^DIOD[7:5];

  always_comb begin
    wr_data = W'(lc_data);
    for (int i = 16; i < W; i++) wr_data[i] = (TWOS_COMPL != 0) & lc_data[15];
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      m_axis_tvalid[n] = (count_q[n] != '0);
      full[n]          = (count_q[n] == CNT_W'(FIFO_DEPTH));
      pop[n]           = m_axis_tvalid[n] & m_axis_tready[n];
      push_req[n]      = accept & ~subbus[2] & (subbus[1:0] == 2'(n));
      // A full FIFO still accepts the word when it is popping in the same cycle
      push[n]          = push_req[n] & (~full[n] | pop[n]);
      ovf_new[n]       = push_req[n] & full[n] & ~pop[n];
      count_d[n]       = count_q[n];
      if (push[n] && !pop[n])      count_d[n] = count_q[n] + CNT_W'(1);
      else if (!push[n] && pop[n]) count_d[n] = count_q[n] - CNT_W'(1);
    end
  end

  // Empty channels present zero so that stale memory never shows on the bus
  always_comb begin
    m_axis_tdata = '0;
    for (int n = 0; n < 4; n++) begin
      if (m_axis_tvalid[n]) m_axis_tdata[n*W +: W] = mem_q[n][rptr_q[n]];
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    for (int n = 0; n < 4; n++) begin
      if (push[n]) mem_q[n][wptr_q[n]] <= wr_data;
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      strb_s1_q  <= 1'b0;
      strb_s2_q  <= 1'b0;
      strb_s3_q  <= 1'b0;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
      ovf_flag_q <= 4'b0;
      unmapped_q <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        wptr_q[n]  <= '0;
        rptr_q[n]  <= '0;
        count_q[n] <= '0;
      end
    end else begin
      strb_s1_q  <= DIOD[0];
      strb_s2_q  <= strb_s1_q;
      strb_s3_q  <= strb_s2_q;
      fill_q     <= {fill_q[0], 1'b1};
      armed_q    <= armed_q | (fill_q[1] & ~strb_s2_q);
      // A new event in the clearing cycle wins over the clear
      ovf_flag_q <= (ovf_flag_q & ~{4{ovf_clear}}) | ovf_new;
      unmapped_q <= (unmapped_q & ~ovf_clear) | unm_new;
      for (int n = 0; n < 4; n++) begin
        if (push[n]) wptr_q[n] <= wptr_q[n] + AW'(1);
        if (pop[n])  rptr_q[n] <= rptr_q[n] + AW'(1);
        count_q[n] <= count_d[n];
      end
    end
  end

  assign ovf_flag      = ovf_flag_q;
  assign unmapped_flag = unmapped_q;

`ifdef LC_DISPATCH_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = ovf_clear ? 8'd0 : drop_cnt_q;
    if (((|ovf_new) | unm_new) && drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) drop_cnt_q <= 8'd0;
    else               drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axis_labcontrol_dispatch.sv
// ---------------------------------------------------------------------------
// tb_axis_labcontrol_dispatch
//
// Directed and randomized LabControl writes go to the default 16-bit build.
// Two 24-bit builds, one signed and one unsigned, share the same bus and are
// used for the extension check. Expected channel contents come from per-channel
// queues and sticky flag values that the bench keeps itself.
// ---------------------------------------------------------------------------
module tb_axis_labcontrol_dispatch;

  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  dioa, diob, dioc, diod;
  logic [3:0]  tready;
  logic        ovf_clear;
  logic [63:0] tdata;
  logic [3:0]  tvalid, ovf;
  logic        unm;
  logic [95:0] tdata_s, tdata_z;
  logic [3:0]  tvalid_s, tvalid_z, ovf_s, ovf_z;
  logic        unm_s, unm_z;
  logic [3:0]  tready_24;
`ifdef LC_DISPATCH_DROPCNT_EN
  logic [7:0]  drops, drops_s, drops_z;
`endif

  axis_labcontrol_dispatch dut (
    .m_axis_aclk(clk), .m_axis_areset(rst),
    .DIOA(dioa), .DIOB(diob), .DIOC(dioc), .DIOD(diod),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .ovf_clear(ovf_clear), .ovf_flag(ovf), .unmapped_flag(unm)
`ifdef LC_DISPATCH_DROPCNT_EN
    , .drop_count(drops)
`endif
  );

  axis_labcontrol_dispatch #(.TWOS_COMPL(1), .AXIS_DATA_WIDTH(24)) dut_s (
    .m_axis_aclk(clk), .m_axis_areset(rst),
    .DIOA(dioa), .DIOB(diob), .DIOC(dioc), .DIOD(diod),
    .m_axis_tdata(tdata_s), .m_axis_tvalid(tvalid_s), .m_axis_tready(tready_24),
    .ovf_clear(ovf_clear), .ovf_flag(ovf_s), .unmapped_flag(unm_s)
`ifdef LC_DISPATCH_DROPCNT_EN
    , .drop_count(drops_s)
`endif
  );

  axis_labcontrol_dispatch #(.TWOS_COMPL(0), .AXIS_DATA_WIDTH(24)) dut_z (
    .m_axis_aclk(clk), .m_axis_areset(rst),
    .DIOA(dioa), .DIOB(diob), .DIOC(dioc), .DIOD(diod),
    .m_axis_tdata(tdata_z), .m_axis_tvalid(tvalid_z), .m_axis_tready(tready_24),
    .ovf_clear(ovf_clear), .ovf_flag(ovf_z), .unmapped_flag(unm_z)
`ifdef LC_DISPATCH_DROPCNT_EN
    , .drop_count(drops_z)
`endif
  );

  // scoreboard state
  logic [15:0] exp_q [4][$];
  logic [3:0]  exp_ovf;
  logic        exp_unm;
  int          exp_drops;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_valid_vec();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = (exp_q[c].size() != 0);
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_tvalid"}, 64'(tvalid), 64'(exp_valid_vec()));
    for (int c = 0; c < 4; c++) begin
      if (exp_q[c].size() != 0) chk({tag, "_tdata"}, 64'(tdata[c*16 +: 16]), 64'(exp_q[c][0]));
    end
    chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    chk({tag, "_unmapped"}, 64'(unm), 64'(exp_unm));
`ifdef LC_DISPATCH_DROPCNT_EN
    chk({tag, "_drops"}, 64'(drops), 64'(exp_drops));
`endif
  endtask

  function automatic void model_clear();
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    exp_ovf   = 4'b0;
    exp_unm   = 1'b0;
    exp_drops = 0;
  endfunction

  function automatic void model_drop();
    if (exp_drops < 255) exp_drops++;
  endfunction

  // driver tasks: every drive happens 1 time unit after a rising edge
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    ovf_clear = 1'b1;
    @(posedge clk); #1 ovf_clear = 1'b0;
    exp_ovf = 4'b0; exp_unm = 1'b0; exp_drops = 0;
  endtask

  // One bus write. pop_ch >= 0 pops that channel, and clr raises ovf_clear,
  // both on the edge where the write lands in the FIFO.
  task automatic lc_write(input logic [7:0] addr, input logic dir, input logic [2:0] sub,
                          input logic [15:0] data, input int pop_ch, input logic clr);
    logic acc;
    dioa = data[15:8]; diob = data[7:0]; dioc = addr;
    diod = {3'b000, sub, dir, 1'b1};
    @(posedge clk); #1;                     // E0 sampled strobe
    @(posedge clk); #1;                     // E1, write pending
    chk("latency_pre", 64'(tvalid), 64'(exp_valid_vec()));
    if (pop_ch >= 0) tready[pop_ch] = 1'b1;
    if (clr) ovf_clear = 1'b1;
    @(posedge clk); #1;                     // E2, write lands
    tready = 4'b0; ovf_clear = 1'b0;
    if (clr) begin exp_ovf = 4'b0; exp_unm = 1'b0; exp_drops = 0; end
    if (pop_ch >= 0) void'(exp_q[pop_ch].pop_front());
    acc = (addr == 8'hFF) && !dir;
    if (acc) begin
      if (sub >= 3'd4) begin
        exp_unm = 1'b1; model_drop();
      end else if (exp_q[sub].size() == DEPTH) begin
        exp_ovf[sub] = 1'b1; model_drop();
      end else begin
        exp_q[sub].push_back(data);
      end
    end
    diod[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input int ch);
    if (exp_q[ch].size() == 0) begin
      chk("pop_empty", 64'(tvalid[ch]), 64'(0));
    end else begin
      chk("pop_data", 64'(tdata[ch*16 +: 16]), 64'(exp_q[ch][0]));
      tready[ch] = 1'b1;
      @(posedge clk); #1 tready[ch] = 1'b0;
      void'(exp_q[ch].pop_front());
    end
  endtask

  initial begin
    int pc;
    logic [2:0] sub;
    rst = 1'b1; dioa = 0; diob = 0; dioc = 0; diod = 0;
    tready = 4'b0; tready_24 = 4'b0; ovf_clear = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_tdata", tdata, 64'd0);
    chk("reset_tvalid", 64'(tvalid), 64'd0);
    chk("reset_flags", 64'({ovf, unm}), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // addr FF, subbus 1, data 0x1234
    lc_write(8'hFF, 1'b0, 3'd1, 16'h1234, -1, 1'b0);
    chk("basic_tvalid", 64'(tvalid), 64'h2);
    chk("basic_tdata", 64'(tdata[31:16]), 64'h1234);
    // wrong address, then read direction: nothing happens
    lc_write(8'hFE, 1'b0, 3'd0, 16'h5555, -1, 1'b0);
    check_all("wrong_addr");
    lc_write(8'hFF, 1'b1, 3'd0, 16'h6666, -1, 1'b0);
    check_all("read_dir");
    // 24-bit extension, signed and unsigned
    lc_write(8'hFF, 1'b0, 3'd3, 16'h8001, -1, 1'b0);
    chk("ext_signed", 64'(tdata_s[72 +: 24]), 64'h00FF8001);
    chk("ext_zero", 64'(tdata_z[72 +: 24]), 64'h00008001);
    check_all("ext16");

    // overflow on ch0 with five writes
    do_reset();
    for (int i = 1; i <= 5; i++) lc_write(8'hFF, 1'b0, 3'd0, 16'(i), -1, 1'b0);
    check_all("ovf_fill");
    lc_write(8'hFF, 1'b0, 3'd0, 16'h0006, -1, 1'b1);   // clear and overflow together
    check_all("ovf_clear_race");
    pulse_clear();
    check_all("ovf_cleared");
    for (int i = 0; i < 5; i++) begin pop_check(0); check_all("ovf_drain"); end

    // full ch2, fifth write on the same edge as a pop
    do_reset();
    for (int i = 0; i < 4; i++) lc_write(8'hFF, 1'b0, 3'd2, 16'hA0 + 16'(i), -1, 1'b0);
    lc_write(8'hFF, 1'b0, 3'd2, 16'h00A4, 2, 1'b0);
    check_all("full_pop");
    for (int i = 0; i < 4; i++) begin pop_check(2); check_all("full_pop_drain"); end

    // unmapped subbus, then strobe held high through reset
    do_reset();
    lc_write(8'hFF, 1'b0, 3'd5, 16'h7777, -1, 1'b0);
    check_all("unmapped");
    dioa = 8'h12; diob = 8'h34; dioc = 8'hFF; diod = 8'b0000_0001;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    repeat (6) @(posedge clk);
    #1;
    check_all("strobe_thru_reset");
    diod[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lc_write(8'hFF, 1'b0, 3'd0, 16'h4321, -1, 1'b0);
    check_all("after_reset_write");

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          sub = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
          pc = -1;
          if ($urandom_range(0, 2) == 0) begin
            pc = $urandom_range(0, 3);
            if (exp_q[pc].size() == 0) pc = -1;
          end
          lc_write(($urandom_range(0, 5) == 0) ? 8'hFE : 8'hFF,
                   1'($urandom_range(0, 7) == 0), sub, 16'($urandom), pc, 1'b0);
        end
        6, 7, 8: pop_check($urandom_range(0, 3));
        default: pulse_clear();
      endcase
      check_all("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
